riscy_sequencer: RTL
====================

RISCY_SEQUENCER -- requirements
Module: riscy_sequencer

Interface
REQ-001 CLK  in  1  system clock; all state changes on rising edge.
REQ-002 RST  in  1  synchronous, active-high reset, sampled on rising CLK.
REQ-003 CMD  in  32  instruction register output; [31:28] opcode, [27] IF (immediate flag); rest ignored.
REQ-004 CF, ZF  in  1 each  ALU carry/zero flags.
REQ-005 MEM_RDY  in  1  RAM ready; 1 = access completes this cycle.
REQ-006 PHASE  out  3  current phase code: FETCH=000, DECODE=001, EXECUTE=010, STORE=011, WAIT=100, HALT=111.
REQ-007 IR_EN, PC_EN, PC_LOAD, A_EN, B_EN  out  1 each  register/PC strobes.
REQ-008 ALU_EN, ALU_OE, RAM_CS, RAM_OE, RDR_EN, IMM_OE  out  1 each  datapath and bus-driver strobes.
REQ-009 PORT_EN, PORT_RD, PDR_EN  out  1 each  I/O port write, read and direction-register strobes.
REQ-010 HALTED  out  1  1 while in HALT.

Function
REQ-011 FSM SHALL cycle FETCH -> DECODE -> EXECUTE -> STORE -> FETCH, one cycle per phase unless stalled or halted.
REQ-012 All outputs SHALL be Moore: decoded from registered phase and CMD[31:27], held for the whole phase.
REQ-013 FETCH: IR_EN=1 only.
REQ-014 DECODE: PC_EN=1 (PC increment) for every opcode except HLT (1111).
REQ-015 EXECUTE by opcode: 0000 NOP none; 0001 LDA A_EN plus source; 0010 LDB B_EN plus source; 0011 ALU ALU_EN; 0100 STR RAM_CS; 0101 IN PORT_RD+A_EN; 0110 OUT PORT_EN; 0111 DIR PDR_EN; 1000 JMP PC_LOAD; 1001 JZ PC_LOAD iff ZF; 1010 JC PC_LOAD iff CF; 1111 HLT none; 1011-1110 treated as NOP.
REQ-016 Load source: IF=1 -> IMM_OE=1 with RAM_CS=RAM_OE=0; IF=0 -> RAM_CS=RAM_OE=1.
REQ-017 STORE by opcode: 0011 ALU_OE+A_EN; 0100 STR RAM_CS+RDR_EN; all others no strobe.
REQ-018 ZF/CF SHALL be sampled in EXECUTE, not earlier.
REQ-019 Stall: in any phase with RAM_CS=1 and MEM_RDY=0, FSM SHALL go to WAIT at next edge, store the return phase, and hold all of that phase's strobes in WAIT.
REQ-020 WAIT SHALL continue to the phase following the stalled one on the first cycle MEM_RDY=1; it has no timeout.
REQ-021 PC_LOAD, A_EN, B_EN SHALL assert only in the cycle MEM_RDY=1 when RAM is the source, never in a stalled cycle (no double load).
REQ-022 HLT: after EXECUTE of 1111 FSM SHALL enter HALT, all strobes 0, HALTED=1, and stay there until RST.
REQ-023 At most one of ALU_OE, RAM_OE, IMM_OE, PORT_RD SHALL be 1 in any cycle (single bus driver).
REQ-024 CMD changes outside FETCH SHALL not alter the current instruction's strobes; the opcode is latched at end of DECODE.

Reset
REQ-025 RST=1 SHALL force PHASE=FETCH, every strobe 0, HALTED=0 and the latched opcode to NOP in the next cycle, whatever the current phase, including WAIT and HALT.
REQ-026 After RST deasserts, the first FETCH (IR_EN=1) SHALL occur in the first cycle with RST=0.

Structure
REQ-027 Package riscy_pkg SHALL hold the phase enum/encodings and the 4-bit opcode constants, shared with the core and the bench.
REQ-028 One sub-module riscy_decode (combinational phase+opcode+flags -> strobes) is used; FSM and WAIT logic stay in riscy_sequencer.

Verification
REQ-029 RST high 2 cycles, then low, CMD=0000 -> PHASE 000,001,010,011,000; IR_EN in FETCH only; PC_EN in DECODE only.
REQ-030 CMD=0001 IF=0, MEM_RDY=0 for 3 cycles in EXECUTE -> WAIT for 3 cycles with RAM_CS=RAM_OE=1; A_EN=1 in exactly one cycle, the MEM_RDY=1 cycle; then STORE.
REQ-031 CMD=0001 IF=1 -> IMM_OE=1 and A_EN=1 in EXECUTE; RAM_CS=0; no WAIT even when MEM_RDY=0.
REQ-032 JZ (1001) with ZF=1 -> PC_LOAD=1 in EXECUTE; with ZF=0 -> PC_LOAD stays 0; JC with CF=1 -> PC_LOAD=1.
REQ-033 CMD=1111 -> HALT reached after EXECUTE, HALTED=1 for 20 cycles with all strobes 0; RST pulse -> FETCH next cycle.
REQ-034 RST asserted during WAIT (MEM_RDY=0) -> next cycle PHASE=000, all strobes 0; each cycle of every test checks the REQ-023 single-driver rule.

Source files
------------

// File: rtl/riscy_pkg.sv
// Shared phase encodings, opcode constants and strobe bundle for the riscy sequencer.
package riscy_pkg;

    localparam int unsigned CMD_W   = 32;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned PHASE_W = 3;

    typedef enum logic [PHASE_W-1:0] {
        PH_FETCH   = 3'b000,
        PH_DECODE  = 3'b001,
        PH_EXECUTE = 3'b010,
        PH_STORE   = 3'b011,
        PH_WAIT    = 3'b100,
        PH_HALT    = 3'b111
    } phase_t;

    localparam logic [OP_W-1:0] OP_NOP = 4'h0;
    localparam logic [OP_W-1:0] OP_LDA = 4'h1;
    localparam logic [OP_W-1:0] OP_LDB = 4'h2;
    localparam logic [OP_W-1:0] OP_ALU = 4'h3;
    localparam logic [OP_W-1:0] OP_STR = 4'h4;
    localparam logic [OP_W-1:0] OP_IN  = 4'h5;
    localparam logic [OP_W-1:0] OP_OUT = 4'h6;
    localparam logic [OP_W-1:0] OP_DIR = 4'h7;
    localparam logic [OP_W-1:0] OP_JMP = 4'h8;
    localparam logic [OP_W-1:0] OP_JZ  = 4'h9;
    localparam logic [OP_W-1:0] OP_JC  = 4'hA;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;

    typedef struct packed {
        logic ir_en;
        logic pc_en;
        logic pc_load;
        logic a_en;
        logic b_en;
        logic alu_en;
        logic alu_oe;
        logic ram_cs;
        logic ram_oe;
        logic rdr_en;
        logic imm_oe;
        logic port_en;
        logic port_rd;
        logic pdr_en;
    } strobes_t;

    // Phase that follows a completed (non-stalled) phase.
    function automatic phase_t next_phase(input phase_t p, input logic [OP_W-1:0] op);
        case (p)
            PH_FETCH:   return PH_DECODE;
            PH_DECODE:  return PH_EXECUTE;
            PH_EXECUTE: return (op == OP_HLT) ? PH_HALT : PH_STORE;
            default:    return PH_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/riscy_decode.sv
// Combinational strobe decode from phase, opcode, immediate flag and ALU flags.
module riscy_decode
    import riscy_pkg::*;
(
    input  phase_t          phase,
    input  logic [OP_W-1:0] op,
    input  logic            imm,
    input  logic            zf,
    input  logic            cf,
    input  logic            mem_rdy,
    output strobes_t        strb
);

    always_comb begin
        strb = '0;
        case (phase)
            PH_FETCH:  strb.ir_en = 1'b1;
            PH_DECODE: strb.pc_en = (op != OP_HLT);
            PH_EXECUTE: begin
                case (op)
                    OP_LDA, OP_LDB: begin
                        strb.a_en = (op == OP_LDA);
                        strb.b_en = (op == OP_LDB);
                        if (imm) begin
                            strb.imm_oe = 1'b1;
                        end else begin
                            strb.ram_cs = 1'b1;
                            strb.ram_oe = 1'b1;
                        end
                    end
                    OP_ALU: strb.alu_en  = 1'b1;
                    OP_STR: strb.ram_cs  = 1'b1;
                    OP_IN: begin
                        strb.port_rd = 1'b1;
                        strb.a_en    = 1'b1;
                    end
                    OP_OUT: strb.port_en = 1'b1;
                    OP_DIR: strb.pdr_en  = 1'b1;
                    OP_JMP: strb.pc_load = 1'b1;
                    OP_JZ:  strb.pc_load = zf;
                    OP_JC:  strb.pc_load = cf;
                    default: ;
                endcase
            end
            PH_STORE: begin
                case (op)
                    OP_ALU: begin
                        strb.alu_oe = 1'b1;
                        strb.a_en   = 1'b1;
                    end
                    OP_STR: begin
                        strb.ram_cs = 1'b1;
                        strb.rdr_en = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
        // Register loads fire only in the cycle the RAM access actually completes.
        if (strb.ram_cs && !mem_rdy) begin
            strb.a_en    = 1'b0;
            strb.b_en    = 1'b0;
            strb.pc_load = 1'b0;
        end
    end

endmodule

// File: rtl/riscy_sequencer.sv
// Instruction phase sequencer: FETCH/DECODE/EXECUTE/STORE with RAM wait-state and halt.
module riscy_sequencer
    import riscy_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [CMD_W-1:0]   cmd,
    input  logic               cf,
    input  logic               zf,
    input  logic               mem_rdy,
    output logic [PHASE_W-1:0] phase,
    output logic               ir_en,
    output logic               pc_en,
    output logic               pc_load,
    output logic               a_en,
    output logic               b_en,
    output logic               alu_en,
    output logic               alu_oe,
    output logic               ram_cs,
    output logic               ram_oe,
    output logic               rdr_en,
    output logic               imm_oe,
    output logic               port_en,
    output logic               port_rd,
    output logic               pdr_en,
    output logic               halted
);

    phase_t          state_q, state_d;
    phase_t          ret_q, ret_d;
    logic [OP_W-1:0] op_q, op_d;
    logic            imm_q, imm_d;
    phase_t          eff_phase;
    logic [OP_W-1:0] op_sel;
    logic            imm_sel;
    logic            stall;
    strobes_t        strb;
    strobes_t        strb_out;
    logic            cmd_unused;

    assign cmd_unused = ^cmd[26:0];

    // WAIT replays the strobes of the phase it is standing in for.
    assign eff_phase = (state_q == PH_WAIT) ? ret_q : state_q;
    assign op_sel    = (state_q == PH_DECODE) ? cmd[31:28] : op_q;
    assign imm_sel   = (state_q == PH_DECODE) ? cmd[27] : imm_q;
    assign stall     = strb.ram_cs & ~mem_rdy;

    riscy_decode u_decode (
        .phase   (eff_phase),
        .op      (op_sel),
        .imm     (imm_sel),
        .zf      (zf),
        .cf      (cf),
        .mem_rdy (mem_rdy),
        .strb    (strb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PH_FETCH;
            ret_q   <= PH_FETCH;
            op_q    <= OP_NOP;
            imm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            op_q    <= op_d;
            imm_q   <= imm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        op_d    = op_q;
        imm_d   = imm_q;
        case (state_q)
            PH_HALT: state_d = PH_HALT;
            PH_WAIT: begin
                if (mem_rdy) state_d = next_phase(ret_q, op_q);
            end
            PH_FETCH, PH_DECODE, PH_EXECUTE, PH_STORE: begin
                if (stall) begin
                    state_d = PH_WAIT;
                    ret_d   = state_q;
                end else begin
                    state_d = next_phase(state_q, op_sel);
                end
            end
            default: state_d = PH_FETCH;
        endcase
        // Instruction is frozen at the end of DECODE; later CMD changes are ignored.
        if (state_q == PH_DECODE) begin
            op_d  = cmd[31:28];
            imm_d = cmd[27];
        end
    end

    assign strb_out = rst ? '0 : strb;

    assign phase   = state_q;
    assign ir_en   = strb_out.ir_en;
    assign pc_en   = strb_out.pc_en;
    assign pc_load = strb_out.pc_load;
    assign a_en    = strb_out.a_en;
    assign b_en    = strb_out.b_en;
    assign alu_en  = strb_out.alu_en;
    assign alu_oe  = strb_out.alu_oe;
    assign ram_cs  = strb_out.ram_cs;
    assign ram_oe  = strb_out.ram_oe;
    assign rdr_en  = strb_out.rdr_en;
    assign imm_oe  = strb_out.imm_oe;
    assign port_en = strb_out.port_en;
    assign port_rd = strb_out.port_rd;
    assign pdr_en  = strb_out.pdr_en;
    assign halted  = (state_q == PH_HALT);

endmodule
